// File: rtl/fft_symbol_scheduler.sv
// Cyclic-prefix removal and per-symbol gating between frame_sync and the FFT demod core.
// Optional statistics ports (dropped_sym_cnt_o, sym_fwd_o) are enabled by FFT_SCHED_STATS_EN.
module fft_symbol_scheduler #(
  parameter int IN_DW      = 32,
  parameter int NFFT       = 8,
  parameter int CP_ADVANCE = 4,
  parameter int USER_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [IN_DW-1:0]      s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_in_tuser,
  input  logic                  s_axis_in_tlast,
  input  logic                  s_axis_in_tvalid,
  input  logic [13:0]           sym_mask_i,
  output logic [IN_DW-1:0]      m_axis_out_tdata,
  output logic [18:0]           m_axis_out_tuser,
  output logic                  m_axis_out_tlast,
  output logic                  m_axis_out_tvalid,
  input  logic                  m_axis_out_tready,
  output logic                  overrun_o,
  output logic                  sync_err_o
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]           dropped_sym_cnt_o,
  output logic                  sym_fwd_o
`endif
);

  localparam int FFT_LEN = 2 ** NFFT;
  localparam int CW      = $clog2(FFT_LEN + 20);
  localparam int MW      = USER_WIDTH - 5;

  // Handshake: an input beat is any cycle with s_axis_in_tvalid high (no back-pressure).
  // m_axis_out_tready is consulted on the input beat itself; the forwarded beat
  // appears registered one cycle later with m_axis_out_tvalid high for exactly one cycle.
  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    SKIP_CP   = 3'd1,
    PASS      = 3'd2,
    DROP      = 3'd3,
    TAIL      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      cp_q;
  logic [MW-1:0]   meta_q;
  logic            mask_q;

  logic            first_beat;
  logic [4:0]      cur_cp;
  logic [MW-1:0]   cur_meta;
  logic            cur_mask;
  logic [15:0]     mask_ext;
  logic [CW-1:0]   cp_ext;
  logic [CW-1:0]   win_start;
  logic [CW-1:0]   win_end;
  logic [CW-1:0]   sym_end;
  logic            at_end;

  logic            fwd;
  logic            fwd_last;
  logic            set_ovr;
  logic            err;
  logic            latch;
  logic            ovr_drop;

  // The first beat of a symbol is used directly so a zero-length skip window still works.
  assign mask_ext   = {2'b00, sym_mask_i};
  assign first_beat = (state_q == SKIP_CP) && (cnt_q == '0);
  assign cur_cp     = first_beat ? s_axis_in_tuser[4:0] : cp_q;
  assign cur_meta   = first_beat ? s_axis_in_tuser[USER_WIDTH-1:5] : meta_q;
  assign cur_mask   = first_beat ? mask_ext[s_axis_in_tuser[8:5]] : mask_q;
  assign cp_ext     = CW'(cur_cp);
  assign win_start  = (cp_ext > CW'(CP_ADVANCE)) ? cp_ext - CW'(CP_ADVANCE) : '0;
  assign win_end    = win_start + CW'(FFT_LEN - 1);
  assign sym_end    = cp_ext + CW'(FFT_LEN - 1);
  assign at_end     = (cnt_q == sym_end);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fwd      = 1'b0;
    fwd_last = 1'b0;
    set_ovr  = 1'b0;
    err      = 1'b0;
    latch    = 1'b0;
    ovr_drop = 1'b0;
    if (s_axis_in_tvalid) begin
      if (state_q == WAIT_SYNC) begin
        if (s_axis_in_tlast) begin
          state_d = SKIP_CP;
          cnt_d   = '0;
        end
      end else begin
        latch = first_beat;
        cnt_d = cnt_q + CW'(1);
        case (state_q)
          SKIP_CP: begin
            if (cnt_q == win_start) begin
              if (!cur_mask) begin
                state_d = DROP;
              end else if (m_axis_out_tready) begin
                state_d = PASS;
                fwd     = 1'b1;
              end else begin
                state_d  = DROP;
                set_ovr  = 1'b1;
                ovr_drop = 1'b1;
              end
            end
          end
          PASS: begin
            if (m_axis_out_tready) fwd = 1'b1;
            else                   set_ovr = 1'b1;
            if (cnt_q == win_end) begin
              state_d  = TAIL;
              fwd_last = m_axis_out_tready;
            end
          end
          DROP: begin
            if (cnt_q == win_end) state_d = TAIL;
          end
          default: ;
        endcase
        // Framing checks override the normal progression; an early tlast closes the FFT frame.
        if (s_axis_in_tlast && !at_end) begin
          err      = 1'b1;
          state_d  = SKIP_CP;
          cnt_d    = '0;
          fwd_last = fwd;
        end else if (at_end) begin
          cnt_d = '0;
          if (s_axis_in_tlast) begin
            state_d = SKIP_CP;
          end else begin
            err     = 1'b1;
            state_d = WAIT_SYNC;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= WAIT_SYNC;
      cnt_q             <= '0;
      cp_q              <= '0;
      meta_q            <= '0;
      mask_q            <= 1'b0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= '0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      overrun_o         <= 1'b0;
      sync_err_o        <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      if (latch) begin
        cp_q   <= cur_cp;
        meta_q <= cur_meta;
        mask_q <= cur_mask;
      end
      m_axis_out_tvalid <= fwd;
      m_axis_out_tlast  <= fwd_last;
      if (fwd) begin
        m_axis_out_tdata <= s_axis_in_tdata;
        m_axis_out_tuser <= cur_meta;
      end
      overrun_o         <= overrun_o | set_ovr;
      sync_err_o        <= err;
    end
  end

`ifdef FFT_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dropped_sym_cnt_o <= '0;
      sym_fwd_o         <= 1'b0;
    end else begin
      sym_fwd_o <= fwd_last;
      if (ovr_drop && (dropped_sym_cnt_o != 16'hFFFF))
        dropped_sym_cnt_o <= dropped_sym_cnt_o + 16'd1;
    end
  end
`else
  logic unused_ovr_drop;
  assign unused_ovr_drop = ovr_drop;
`endif

endmodule

// File: tb/tb_fft_symbol_scheduler.sv
// Directed bench for fft_symbol_scheduler: nominal, masking, overrun, framing errors, reset.
// Builds with or without FFT_SCHED_STATS_EN.
module tb_fft_symbol_scheduler;
  localparam int IN_DW = 32;
  localparam int UW    = 24;
  localparam int RW    = 46;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [IN_DW-1:0]  s_tdata;
  logic [UW-1:0]     s_tuser;
  logic              s_tlast;
  logic              s_tvalid;
  logic [13:0]       sym_mask;
  logic [IN_DW-1:0]  m_tdata;
  logic [18:0]       m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              overrun;
  logic              sync_err;
`ifdef FFT_SCHED_STATS_EN
  logic [15:0]       dropped_cnt;
  logic              sym_fwd;
`endif

  always #5 clk = ~clk;

  fft_symbol_scheduler dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .s_axis_in_tdata   (s_tdata),
    .s_axis_in_tuser   (s_tuser),
    .s_axis_in_tlast   (s_tlast),
    .s_axis_in_tvalid  (s_tvalid),
    .sym_mask_i        (sym_mask),
    .m_axis_out_tdata  (m_tdata),
    .m_axis_out_tuser  (m_tuser),
    .m_axis_out_tlast  (m_tlast),
    .m_axis_out_tvalid (m_tvalid),
    .m_axis_out_tready (m_tready),
    .overrun_o         (overrun),
    .sync_err_o        (sync_err)
`ifdef FFT_SCHED_STATS_EN
    ,
    .dropped_sym_cnt_o (dropped_cnt),
    .sym_fwd_o         (sym_fwd)
`endif
  );

  int n_checks = 0;
  int n_bad    = 0;
  logic [RW-1:0] exp_q[$];
  int out_beats = 0;
  int err_cnt   = 0;
  int cur_beats = 0;
  logic [8:0] cur_first = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: one record per framed output symbol {tuser, beats, first idx, last idx}.
  always @(negedge clk) begin
    logic [RW-1:0] rec;
    if (sync_err) err_cnt++;
    if (m_tvalid) begin
      out_beats++;
      if (cur_beats == 0) cur_first = m_tdata[8:0];
      cur_beats++;
      if (m_tlast) begin
        rec = {m_tuser, 9'(cur_beats), cur_first, m_tdata[8:0]};
        if (exp_q.size() == 0) check_eq("extra_sym", 64'(exp_q.size()), 64'd1);
        else check_eq("sym_rec", 64'(rec), 64'(exp_q.pop_front()));
        cur_beats = 0;
      end
    end
    if (reset_i) cur_beats = 0;
  end

  task automatic beat(input logic [31:0] d, input logic [23:0] u, input logic l,
                      input logic r, input logic rst);
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    m_tready = r;
    reset_i  = rst;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    reset_i  = 1'b0;
  endtask

  task automatic send_sym(input int cp, input int sym, input int len, input bit has_last,
                          input int lo_s, input int lo_n, input int rst_at);
    logic [23:0] u;
    u = {10'd5, 5'd3, 4'(sym), 5'(cp)};
    for (int i = 0; i < len; i++) begin
      beat({8'(sym), 8'h00, 16'(i)}, u, has_last && (i == len - 1),
           !((i >= lo_s) && (i < lo_s + lo_n)), i == rst_at);
      if (i == rst_at) begin
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(m_tlast), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
      end
    end
  endtask

  task automatic nominal(input int sym, input int cp);
    send_sym(cp, sym, cp + 256, 1'b1, 0, 0, -1);
  endtask

  task automatic expect_sym(input int sym, input int beats, input int first, input int last);
    exp_q.push_back({10'd5, 5'd3, 4'(sym), 9'(beats), 9'(first), 9'(last)});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle(2);
    reset_i = 1'b0;
  endtask

  initial begin
    int b0;
    int e0;
    int cp;
    reset_i  = 1'b1;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    sym_mask = 14'h3FFF;
    idle(3);
    check_eq("reset_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("reset_tlast", 64'(m_tlast), 64'd0);
    check_eq("reset_tdata", 64'(m_tdata), 64'd0);
    check_eq("reset_tuser", 64'(m_tuser), 64'd0);
    check_eq("reset_overrun", 64'(overrun), 64'd0);
    check_eq("reset_sync_err", 64'(sync_err), 64'd0);
    reset_i = 1'b0;

    // Preamble symbol only establishes alignment; nothing is forwarded.
    send_sym(18, 13, 20, 1'b1, 0, 0, -1);
    idle(2);
    check_eq("preamble_beats", 64'(out_beats), 64'd0);

    // Nominal slot, cp 20 on symbols 0 and 7, cp 18 elsewhere.
    b0 = out_beats; e0 = err_cnt;
    for (int s = 0; s < 14; s++) begin
      cp = (s == 0 || s == 7) ? 20 : 18;
      expect_sym(s, 256, cp - 4, cp - 4 + 255);
      nominal(s, cp);
    end
    idle(2);
    check_eq("nominal_beats", 64'(out_beats - b0), 64'd3584);
    check_eq("nominal_err", 64'(err_cnt - e0), 64'd0);
    check_eq("nominal_overrun", 64'(overrun), 64'd0);
    check_eq("nominal_pending", 64'(exp_q.size()), 64'd0);

    // Mask selects only symbol 2.
    sym_mask = 14'h0004;
    b0 = out_beats; e0 = err_cnt;
    for (int s = 0; s < 4; s++) begin
      if (s == 2) expect_sym(2, 256, 14, 269);
      nominal(s, 18);
    end
    idle(2);
    check_eq("mask_beats", 64'(out_beats - b0), 64'd256);
    check_eq("mask_err", 64'(err_cnt - e0), 64'd0);
    sym_mask = 14'h3FFF;

    // tready low exactly at the window start of symbol 5.
    b0 = out_beats; e0 = err_cnt;
    expect_sym(4, 256, 14, 269);
    nominal(4, 18);
    send_sym(18, 5, 274, 1'b1, 14, 1, -1);
    expect_sym(6, 256, 14, 269);
    nominal(6, 18);
    idle(2);
    check_eq("ovr_sym_overrun", 64'(overrun), 64'd1);
    check_eq("ovr_sym_beats", 64'(out_beats - b0), 64'd512);
    check_eq("ovr_sym_err", 64'(err_cnt - e0), 64'd0);
`ifdef FFT_SCHED_STATS_EN
    check_eq("dropped_cnt", 64'(dropped_cnt), 64'd1);
`endif

    do_reset();
    check_eq("reset2_overrun", 64'(overrun), 64'd0);
    send_sym(18, 13, 20, 1'b1, 0, 0, -1);

    // Three stalled beats mid-window: 253 beats, tlast still on input index 269.
    b0 = out_beats;
    expect_sym(7, 253, 14, 269);
    send_sym(18, 7, 274, 1'b1, 50, 3, -1);
    idle(2);
    check_eq("stall_beats", 64'(out_beats - b0), 64'd253);
    check_eq("stall_overrun", 64'(overrun), 64'd1);

    // Input tlast 10 beats early closes the frame at index 263 and realigns.
    b0 = out_beats; e0 = err_cnt;
    expect_sym(8, 250, 14, 263);
    send_sym(18, 8, 264, 1'b1, 0, 0, -1);
    expect_sym(9, 256, 14, 269);
    nominal(9, 18);
    idle(2);
    check_eq("early_err", 64'(err_cnt - e0), 64'd1);
    check_eq("early_beats", 64'(out_beats - b0), 64'd506);

    // Missing tlast: symbol still forwarded, then resync discards the next symbol.
    b0 = out_beats; e0 = err_cnt;
    expect_sym(10, 256, 14, 269);
    send_sym(18, 10, 274, 1'b0, 0, 0, -1);
    nominal(11, 18);
    expect_sym(12, 256, 14, 269);
    nominal(12, 18);
    idle(2);
    check_eq("nolast_err", 64'(err_cnt - e0), 64'd1);
    check_eq("nolast_beats", 64'(out_beats - b0), 64'd512);

    // Degenerate window: cp equals the advance, window opens on beat 0.
    b0 = out_beats;
    expect_sym(0, 256, 0, 255);
    nominal(0, 4);
    expect_sym(1, 256, 14, 269);
    nominal(1, 18);
    idle(2);
    check_eq("degen_beats", 64'(out_beats - b0), 64'd512);

    // Reset on beat 100 of the window: 100 beats out, no tlast, resync on input tlast.
    b0 = out_beats; e0 = err_cnt;
    send_sym(18, 2, 274, 1'b1, 0, 0, 114);
    idle(2);
    check_eq("rst_mid_beats", 64'(out_beats - b0), 64'd100);
    expect_sym(3, 256, 14, 269);
    nominal(3, 18);
    idle(2);
    check_eq("rst_resync_beats", 64'(out_beats - b0), 64'd356);
    check_eq("rst_err", 64'(err_cnt - e0), 64'd0);

    check_eq("final_pending", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_symbol_scheduler.md
Name: fft_symbol_scheduler

Overview:
- Sits between frame_sync and the FFT_demod core.
- Consumes the symbol-aligned sample stream from frame_sync, removes the cyclic prefix with a configurable advance, and gates each symbol to the FFT using a per-slot symbol mask.
- Frames each forwarded symbol with tlast and attaches symbol metadata.
- Reports overruns when the FFT is not ready and framing errors when the input symbol length does not match its CP length.

Parameters:
- IN_DW, 32, sample width (I/Q packed).
- NFFT, 8, log2 FFT length; FFT_LEN = 2**NFFT.
- CP_ADVANCE, 4, samples of CP kept before the FFT window (timing margin); must be < CP2_LEN = 18*FFT_LEN/256.
- USER_WIDTH, 24, input tuser width. Layout MSB→LSB: sfn[23:14], subframe[13:9], sym[8:5], cp_len[4:0].

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- s_axis_in_tdata  in  IN_DW  sample.
- s_axis_in_tuser  in  USER_WIDTH  metadata; valid on every beat, constant within a symbol.
- s_axis_in_tlast  in  1  last sample of a symbol (CP+FFT_LEN samples).
- s_axis_in_tvalid  in  1  sample valid; there is no input tready.
- sym_mask_i  in  14  bit n = 1 forwards symbol n of the slot.
- m_axis_out_tdata  out  IN_DW  FFT input sample.
- m_axis_out_tuser  out  19  {sfn, subframe, sym}.
- m_axis_out_tlast  out  1  last of FFT_LEN samples.
- m_axis_out_tvalid  out  1  sample valid.
- m_axis_out_tready  in  1  FFT ready.
- overrun_o  out  1  sticky; set when a sample is lost to !tready.
- sync_err_o  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset:
  - All outputs 0, counters 0, state WAIT_SYNC.
  - Reset mid-symbol drops the partial symbol; no tlast is emitted.
- Latency: fixed 1 cycle, input beat to output beat (registered outputs).
- Handshake:
  - Output beats occur only on input beats.
  - m_axis_out_tready is sampled on the first kept sample of a symbol:
    - tready low → whole symbol goes to DROP, overrun_o set.
    - tready high → symbol goes to PASS.
  - In PASS, any beat with tready = 0 discards that sample and sets overrun_o; the position counter still advances, so tlast stays on input index cp_len - CP_ADVANCE + FFT_LEN - 1.
  - overrun_o clears only on reset.
- States (sample_cnt counts valid input beats within a symbol; metadata and mask bit latched on the first beat):
  - WAIT_SYNC: discard input. On an input tlast beat → SKIP_CP at the next beat.
  - SKIP_CP: discard the first cp_len - CP_ADVANCE beats. When entering the window:
    - mask bit for sym clear → DROP;
    - otherwise sample tready and go to PASS or DROP.
  - PASS: forward FFT_LEN beats. m_axis_out_tlast on the FFT_LEN-th beat, then TAIL.
  - DROP: discard FFT_LEN beats, then TAIL.
  - TAIL: discard the remaining CP_ADVANCE beats. The beat carrying input tlast returns to SKIP_CP.
- Degenerate window: if cp_len - CP_ADVANCE == 0, the first beat of the symbol is already in the window.
- Framing checks:
  - Input tlast before the expected symbol end: sync_err_o pulse, go to SKIP_CP. If in PASS, that beat is forwarded with m_axis_out_tlast = 1 so the FFT stays framed.
  - Expected symbol end (cp_len + FFT_LEN beats) without input tlast: sync_err_o pulse, go to WAIT_SYNC.
- Simultaneous events:
  - Input tlast with reset: reset wins.
  - sym_mask_i changes mid-symbol: no effect until the next symbol start.
- Widths: sample_cnt is $clog2(FFT_LEN + 20) bits; cp_len is taken unsigned from tuser[4:0].

Optional Feature:
- Macro FFT_SCHED_STATS_EN.
- Defined:
  - Adds output port dropped_sym_cnt_o [15:0].
  - Counts symbols dropped for overrun (mask drops excluded); saturates at 16'hFFFF; reset to 0.
  - Adds one-cycle pulse port sym_fwd_o, asserted with each forwarded tlast.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Nominal, NFFT=8, CP_ADVANCE=4, mask = 14'h3FFF, tready = 1, contiguous symbols with cp 20/18 → per symbol exactly 256 out beats, first output = input index 16 (cp 20) or 14 (cp 18), tlast on the 256th beat, tuser sym increments 0..13.
- Mask 14'h0004 → only sym 2 forwarded (256 beats); no tvalid for other symbols; sync_err_o stays 0.
- tready = 0 at window start of sym 5 → no output for sym 5, overrun_o = 1, next symbol forwarded normally; with FFT_SCHED_STATS_EN, dropped_sym_cnt_o = 1.
- tready low for 3 beats mid-PASS → 253 output beats, tlast still at input index cp-4+255, overrun_o = 1.
- Input tlast 10 beats early in PASS → sync_err_o pulse, m tlast on that beat, the following symbol realigned and forwarded with 256 beats.
- Reset asserted at beat 100 of PASS → outputs 0 next cycle; no output until after the next input tlast.
